// File: rtl/morse_key_decoder.sv
// Morse key decoder: synchronises and debounces the operator key, measures
// press and gap lengths in divided_clk time units, classifies dots and dashes,
// packs them into a character code and flags character and word boundaries.
module morse_key_decoder #(
  parameter int DEB_CYCLES = 16,
  parameter int DASH_UNITS = 3,
  parameter int CHAR_GAP   = 3,
  parameter int WORD_GAP   = 7,
  parameter int MAX_SYMS   = 5
) (
  input  logic                            clk_in,
  input  logic                            rst_n,
  input  logic                            divided_clk,
  input  logic                            key,
  output logic                            sym_valid,
  output logic                            sym_dash,
  output logic                            char_valid,
  output logic [MAX_SYMS-1:0]             char_code,
  output logic [$clog2(MAX_SYMS+1)-1:0]   char_len,
  output logic                            char_err,
  output logic                            word_end,
  output logic                            key_db
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(DASH_UNITS + 1);
  localparam int GW = $clog2(WORD_GAP + 1);
  localparam int CW = MAX_SYMS;
  localparam int LW = $clog2(MAX_SYMS + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] DASH_MAX  = PW'(DASH_UNITS);
  localparam logic [GW-1:0] CHAR_LAST = GW'(CHAR_GAP - 1);
  localparam logic [GW-1:0] WORD_LAST = GW'(WORD_GAP - 1);
  localparam logic [GW-1:0] WORD_MAX  = GW'(WORD_GAP);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_SYMS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Front end registers
  logic          div_q;
  logic          key_s1_q;
  logic          key_sync_q;
  logic [DW-1:0] deb_cnt_q;
  logic          key_db_q;
  logic          unit_s;
  logic          press_dash_s;

  // FSM and accumulator
  state_e        state_q, state_d;
  logic [PW-1:0] press_cnt_q, press_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [CW-1:0] code_q, code_d;
  logic [LW-1:0] len_q, len_d;
  logic          err_q, err_d;

  // Registered outputs
  logic          sym_valid_q, sym_valid_d;
  logic          sym_dash_q, sym_dash_d;
  logic          char_valid_q, char_valid_d;
  logic [CW-1:0] char_code_q, char_code_d;
  logic [LW-1:0] char_len_q, char_len_d;
  logic          char_err_q, char_err_d;
  logic          word_end_q, word_end_d;

  // One unit per rising edge of the divider output (same clock domain).
  assign unit_s       = divided_clk & ~div_q;
  assign press_dash_s = (press_cnt_q >= DASH_MAX);

  // Edge history of divided_clk and two-flop synchroniser for the raw key.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= 1'b0;
      key_s1_q   <= 1'b0;
      key_sync_q <= 1'b0;
    end else begin
      div_q      <= divided_clk;
      key_s1_q   <= key;
      key_sync_q <= key_s1_q;
    end
  end

  // Debounce: the synchronised key must disagree for DEB_CYCLES cycles in a row.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= {DW{1'b0}};
      key_db_q  <= 1'b0;
    end else if (key_sync_q == key_db_q) begin
      deb_cnt_q <= {DW{1'b0}};
    end else if (deb_cnt_q == DEB_LAST) begin
      key_db_q  <= key_sync_q;
      deb_cnt_q <= {DW{1'b0}};
    end else begin
      deb_cnt_q <= deb_cnt_q + DW'(1);
    end
  end

  // Next-state logic: key level changes take priority over a same-cycle unit tick.
  always_comb begin
    state_d      = state_q;
    press_cnt_d  = press_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    code_d       = code_q;
    len_d        = len_q;
    err_d        = err_q;
    sym_valid_d  = 1'b0;
    sym_dash_d   = sym_dash_q;
    char_valid_d = 1'b0;
    char_code_d  = char_code_q;
    char_len_d   = char_len_q;
    char_err_d   = char_err_q;
    word_end_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key_db_q) begin
          state_d     = ST_PRESS;
          press_cnt_d = {PW{1'b0}};
        end else begin
          state_d     = ST_IDLE;
        end
      end

      ST_PRESS: begin
        if (!key_db_q) begin
          state_d     = ST_GAP;
          gap_cnt_d   = {GW{1'b0}};
          sym_valid_d = 1'b1;
          sym_dash_d  = press_dash_s;
          // A full accumulator keeps its first symbols and only records overflow.
          if (len_q == LEN_MAX) begin
            err_d  = 1'b1;
          end else begin
            code_d = {code_q[CW-2:0], press_dash_s};
            len_d  = len_q + LW'(1);
          end
        end else if (unit_s && (press_cnt_q < DASH_MAX)) begin
          press_cnt_d = press_cnt_q + PW'(1);
        end else begin
          press_cnt_d = press_cnt_q;
        end
      end

      ST_GAP: begin
        if (key_db_q) begin
          state_d     = ST_PRESS;
          press_cnt_d = {PW{1'b0}};
        end else if (unit_s) begin
          if (gap_cnt_q < WORD_MAX) begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end else begin
            gap_cnt_d = gap_cnt_q;
          end
          // Character closes as the gap count reaches CHAR_GAP.
          if ((gap_cnt_q == CHAR_LAST) && (len_q != {LW{1'b0}})) begin
            char_valid_d = 1'b1;
            char_code_d  = code_q;
            char_len_d   = len_q;
            char_err_d   = err_q;
            code_d       = {CW{1'b0}};
            len_d        = {LW{1'b0}};
            err_d        = 1'b0;
          end else begin
            char_valid_d = 1'b0;
          end
          // Word ends as the gap count reaches WORD_GAP; only once the character is flushed.
          if (gap_cnt_q == WORD_LAST) begin
            word_end_d = (len_q == {LW{1'b0}});
            state_d    = ST_IDLE;
          end else begin
            word_end_d = 1'b0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, accumulator and output registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      press_cnt_q  <= {PW{1'b0}};
      gap_cnt_q    <= {GW{1'b0}};
      code_q       <= {CW{1'b0}};
      len_q        <= {LW{1'b0}};
      err_q        <= 1'b0;
      sym_valid_q  <= 1'b0;
      sym_dash_q   <= 1'b0;
      char_valid_q <= 1'b0;
      char_code_q  <= {CW{1'b0}};
      char_len_q   <= {LW{1'b0}};
      char_err_q   <= 1'b0;
      word_end_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      press_cnt_q  <= press_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      code_q       <= code_d;
      len_q        <= len_d;
      err_q        <= err_d;
      sym_valid_q  <= sym_valid_d;
      sym_dash_q   <= sym_dash_d;
      char_valid_q <= char_valid_d;
      char_code_q  <= char_code_d;
      char_len_q   <= char_len_d;
      char_err_q   <= char_err_d;
      word_end_q   <= word_end_d;
    end
  end

  assign sym_valid  = sym_valid_q;
  assign sym_dash   = sym_dash_q;
  assign char_valid = char_valid_q;
  assign char_code  = char_code_q;
  assign char_len   = char_len_q;
  assign char_err   = char_err_q;
  assign word_end   = word_end_q;
  assign key_db     = key_db_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Self-checking bench for morse_key_decoder. Key activity is described as
// (press units, gap units) pairs; the expected symbol/character/word event
// stream is derived from those lengths and compared with what the DUT emits.
module tb_morse_key_decoder;

  localparam int UNIT = 20;   // clk_in cycles per divided_clk period
  localparam int DASH = 3;
  localparam int CGAP = 3;
  localparam int WGAP = 7;
  localparam int MSYM = 5;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       divided_clk;
  logic       key;
  logic       sym_valid, sym_dash, char_valid, char_err, word_end, key_db;
  logic [4:0] char_code;
  logic [2:0] char_len;

  int checks = 0;
  int errors = 0;
  int ucnt = 0;
  int db_hi_cnt = 0;

  // event = {kind[1:0], bit, code[4:0], len[2:0]}; kind 0 sym, 1 char, 2 word
  logic [10:0] act_q[$];
  logic [10:0] exp_q[$];
  int          pr_q[$];
  int          gp_q[$];
  logic [10:0] last_c = 11'd0;
  logic        last_dash = 1'b0;

  morse_key_decoder #(
    .DEB_CYCLES(2), .DASH_UNITS(DASH), .CHAR_GAP(CGAP), .WORD_GAP(WGAP), .MAX_SYMS(MSYM)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .divided_clk(divided_clk), .key(key),
    .sym_valid(sym_valid), .sym_dash(sym_dash), .char_valid(char_valid),
    .char_code(char_code), .char_len(char_len), .char_err(char_err),
    .word_end(word_end), .key_db(key_db)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) ucnt <= (ucnt == UNIT - 1) ? 0 : ucnt + 1;
  assign divided_clk = (ucnt >= UNIT / 2);

  function automatic logic [10:0] mk(input logic [1:0] k, input logic b,
                                     input logic [4:0] c, input logic [2:0] l);
    return {k, b, c, l};
  endfunction

  always @(negedge clk_in) begin
    if (rst_n) begin
      if (key_db) db_hi_cnt <= db_hi_cnt + 1;
      if (sym_valid) act_q.push_back(mk(2'd0, sym_dash, 5'd0, 3'd0));
      if (char_valid) act_q.push_back(mk(2'd1, char_err, char_code, char_len));
      if (word_end) act_q.push_back(mk(2'd2, 1'b0, 5'd0, 3'd0));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
  endtask

  // Reference: symbols from press lengths, characters and words from gap lengths.
  task automatic model();
    int cur[$];
    for (int i = 0; i < pr_q.size(); i++) begin
      logic       d;
      int         n, len;
      logic [4:0] code;
      d = (pr_q[i] >= DASH);
      exp_q.push_back(mk(2'd0, d, 5'd0, 3'd0));
      last_dash = d;
      cur.push_back(int'(d));
      if (gp_q[i] >= CGAP) begin
        n = cur.size();
        len = (n > MSYM) ? MSYM : n;
        code = 5'd0;
        for (int k = 0; k < len; k++) code = {code[3:0], cur[k][0]};
        last_c = mk(2'd1, (n > MSYM), code, 3'(len));
        exp_q.push_back(last_c);
        cur.delete();
        if (gp_q[i] >= WGAP) exp_q.push_back(mk(2'd2, 1'b0, 5'd0, 3'd0));
      end
    end
  endtask

  task automatic align();
    do begin
      @(posedge clk_in);
      #1;
    end while (ucnt != 0);
  endtask

  // A zero-unit press is a short 3-cycle pulse that still passes the debouncer.
  task automatic play();
    align();
    for (int i = 0; i < pr_q.size(); i++) begin
      key = 1'b1;
      if (pr_q[i] == 0) begin
        cycles(3); #1; key = 1'b0; cycles(gp_q[i] * UNIT - 3); #1;
      end else begin
        cycles(pr_q[i] * UNIT); #1; key = 1'b0; cycles(gp_q[i] * UNIT); #1;
      end
    end
  endtask

  task automatic compare(input string tag);
    logic [10:0] a, e;
    cycles(30);
    chk({tag, ":count"}, act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, ":event"}, a, e);
    end
    act_q.delete();
    exp_q.delete();
    chk({tag, ":char_hold"}, {char_err, char_code, char_len}, {last_c[8], last_c[7:0]});
    chk({tag, ":dash_hold"}, sym_dash, last_dash);
  endtask

  task automatic run(input string tag);
    model();
    play();
    compare(tag);
    pr_q.delete();
    gp_q.delete();
  endtask

  initial begin
    int gap_tab[6] = '{1, 2, 3, 4, 6, 8};
    int n, db0;

    rst_n = 1'b0;
    key   = 1'b0;
    cycles(3);
    #1;
    chk("reset_outputs", {sym_valid, sym_dash, char_valid, char_code, char_len,
                          char_err, word_end, key_db}, 32'd0);
    rst_n = 1'b1;
    cycles(5);

    pr_q = '{1};          gp_q = '{8};          run("single_dot");
    pr_q = '{4, 1, 3};    gp_q = '{1, 1, 8};    run("dash_dot_dash");
    pr_q = '{1, 1, 1, 1, 1, 1}; gp_q = '{1, 1, 1, 1, 1, 8}; run("overflow");

    // One-cycle key glitch must not reach the debounced level.
    align();
    db0 = db_hi_cnt;
    key = 1'b1;
    @(posedge clk_in); #1;
    key = 1'b0;
    cycles(40);
    chk("glitch_key_db", db_hi_cnt, db0);
    chk("glitch_events", act_q.size(), 0);

    pr_q = '{1, 3, 1};    gp_q = '{1, 4, 7};    run("a_then_e");
    pr_q = '{0, 2, 3, 1}; gp_q = '{2, 3, 6, 7}; run("boundaries");

    // Reset in the middle of a dash press.
    align();
    key = 1'b1;
    cycles(50);
    #1;
    chk("pre_reset_key_db", key_db, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_press_reset", {sym_valid, sym_dash, char_valid, char_code, char_len,
                            char_err, word_end, key_db}, 32'd0);
    key = 1'b0;
    cycles(5);
    #1;
    rst_n = 1'b1;
    cycles(5);
    act_q.delete();
    last_c = 11'd0;
    last_dash = 1'b0;
    pr_q = '{1};          gp_q = '{8};          run("after_reset");

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        pr_q.push_back($urandom_range(0, 4));
        gp_q.push_back((i == n - 1) ? 8 : gap_tab[$urandom_range(0, 5)]);
      end
      run("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
